// File: rtl/program_loader.sv
// program_loader: streams a boot image into RAM, then releases the CPU from reset
module program_loader #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = 8'h04,
  parameter int RELEASE_DELAY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              restart,
  output logic              inst_input,
  output logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       instruction,
  output logic              RAM_Reset,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              overflow,
  output logic [ADDR_W-1:0] word_count
);
  typedef enum logic [2:0] {CLEAR, LOAD, RELEASE, RUN, ERROR} state_t;
  localparam int CW = $clog2(RELEASE_DELAY + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {{(ADDR_W-2){1'b1}}, 2'b00};
  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [CW-1:0]     cnt;
  // loader FSM: every output is registered and follows the state it enters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= CLEAR;
      ptr         <= START_ADDR;
      cnt         <= '0;
      s_ready     <= 1'b0;
      inst_input  <= 1'b0;
      inst_addr   <= START_ADDR;
      instruction <= '0;
      RAM_Reset   <= 1'b1;
      cpu_reset   <= 1'b1;
      load_done   <= 1'b0;
      overflow    <= 1'b0;
      word_count  <= '0;
    end else begin
      inst_input <= 1'b0;
      case (state)
        CLEAR: begin
          state      <= LOAD;
          RAM_Reset  <= 1'b0;
          s_ready    <= 1'b1;
          ptr        <= START_ADDR;
          word_count <= '0;
        end
        LOAD: if (s_valid && s_ready) begin
          inst_input  <= 1'b1;
          inst_addr   <= ptr;
          instruction <= s_data;
          ptr         <= ptr + ADDR_W'(4);
          word_count  <= word_count + 1'b1;
          if (s_last) begin
            state   <= RELEASE;
            s_ready <= 1'b0;
            cnt     <= '0;
          end else if (ptr == LAST_ADDR) begin
            state    <= ERROR;
            s_ready  <= 1'b0;
            overflow <= 1'b1;
          end
        end
        RELEASE: if (cnt == CW'(RELEASE_DELAY)) begin
          state     <= RUN;
          cpu_reset <= 1'b0;
          load_done <= 1'b1;
        end else cnt <= cnt + 1'b1;
        RUN, ERROR: if (restart) begin
          state       <= CLEAR;
          RAM_Reset   <= 1'b1;
          cpu_reset   <= 1'b1;
          load_done   <= 1'b0;
          overflow    <= 1'b0;
          ptr         <= START_ADDR;
          word_count  <= '0;
          inst_addr   <= START_ADDR;
          instruction <= '0;
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized self-checking bench for program_loader
module tb_program_loader;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset = 1, s_valid = 0, s_last = 0, restart = 0;
  logic [31:0] s_data = 0;
  logic s_ready, inst_input, RAM_Reset, cpu_reset, load_done, overflow;
  logic [7:0] inst_addr, word_count;
  logic [31:0] instruction;
  logic s_valid4 = 0, s_last4 = 0, restart4 = 0;
  logic [31:0] s_data4 = 0;
  logic s_ready4, inst_input4, RAM_Reset4, cpu_reset4, load_done4, overflow4;
  logic [3:0] inst_addr4, word_count4;
  logic [31:0] instruction4;
  int errors = 0, checks = 0;
  logic [31:0] img [7] = '{32'h24020010, 32'h00000000, 32'h18600002, 32'h24420020,
                           32'h24420030, 32'h24420040, 32'h00000008};
  logic [31:0] cur [7];
  logic [31:0] ram [256];
  int writes = 0, writes4 = 0;
  logic zero_write4 = 0;

  program_loader dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .restart(restart), .inst_input(inst_input), .inst_addr(inst_addr),
    .instruction(instruction), .RAM_Reset(RAM_Reset), .cpu_reset(cpu_reset),
    .load_done(load_done), .overflow(overflow), .word_count(word_count)
  );

  program_loader #(.ADDR_W(4), .START_ADDR(4'h4), .RELEASE_DELAY(2)) dut4 (
    .clk(clk), .reset(reset), .s_valid(s_valid4), .s_data(s_data4), .s_last(s_last4),
    .s_ready(s_ready4), .restart(restart4), .inst_input(inst_input4), .inst_addr(inst_addr4),
    .instruction(instruction4), .RAM_Reset(RAM_Reset4), .cpu_reset(cpu_reset4),
    .load_done(load_done4), .overflow(overflow4), .word_count(word_count4)
  );

  // RAM model: captures on the edge that ends a write cycle
  always @(posedge clk) begin
    if (RAM_Reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
      writes <= 0;
    end else if (inst_input) begin
      ram[inst_addr] <= instruction;
      writes <= writes + 1;
    end
  end

  // small-RAM model: counts writes and flags any wrap to address 0
  always @(posedge clk) begin
    if (RAM_Reset4) writes4 <= 0;
    else if (inst_input4) begin
      writes4 <= writes4 + 1;
      if (inst_addr4 == 0) zero_write4 <= 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals;
    check("rst_ready", s_ready, 0);
    check("rst_en", inst_input, 0);
    check("rst_addr", inst_addr, 32'h04);
    check("rst_data", instruction, 0);
    check("rst_ramrst", RAM_Reset, 1);
    check("rst_cpu", cpu_reset, 1);
    check("rst_done", load_done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_count", word_count, 0);
  endtask

  task automatic start;
    reset = 0;
    #1;
    check_reset_vals();
    step();
    step();
    reset = 1;
    check("clear_ramrst", RAM_Reset, 1);
    step();
    check("edge0_ready", s_ready, 1);
    check("edge0_ramrst", RAM_Reset, 0);
    check("edge0_count", word_count, 0);
  endtask

  // mode 0: always valid, 1: alternate cycles, 2: random gaps
  task automatic load(input int n, input int mode, input bit last);
    int i = 0;
    int c = 0;
    while (i < n && c < 1000) begin
      bit v;
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : ($urandom_range(0, 2) != 0);
      check("ready", s_ready, 1);
      s_valid = v;
      s_data = v ? cur[i] : $urandom;
      s_last = last && (i == n - 1);
      step();
      if (v) begin
        check("wr_en", inst_input, 1);
        check("wr_addr", inst_addr, 4 + 4 * i);
        check("wr_data", instruction, cur[i]);
        check("count", word_count, i + 1);
        i++;
      end else check("idle_en", inst_input, 0);
      c++;
    end
    check("beats_taken", i, n);
    s_valid = 0;
    s_last = 0;
  endtask

  task automatic release_check(input int n);
    check("rdy_off", s_ready, 0);
    for (int d = 1; d <= 2; d++) begin
      step();
      check("cpu_hold", cpu_reset, 1);
      check("done_low", load_done, 0);
      if (d == 1) check("wr_end", inst_input, 0);
    end
    step();
    check("cpu_rel", cpu_reset, 0);
    check("load_done", load_done, 1);
    check("final_count", word_count, n);
    check("writes", writes, n);
    for (int i = 0; i < n; i++) check("ram", ram[4 + 4 * i], cur[i]);
  endtask

  task automatic do_restart;
    restart = 1;
    step();
    restart = 0;
    check("rs_ramrst", RAM_Reset, 1);
    check("rs_cpu", cpu_reset, 1);
    check("rs_done", load_done, 0);
    check("rs_ready", s_ready, 0);
    check("rs_count", word_count, 0);
    step();
    check("rs_ramrst_off", RAM_Reset, 0);
    check("rs_ready_on", s_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    cur = img;
    start();
    load(7, 0, 1);
    release_check(7);
    for (int i = 0; i < 3; i++) begin
      step();
      check("run_hold", cpu_reset, 0);
    end
    do_restart();
    load(7, 1, 1);
    release_check(7);
    do_restart();
    restart = 1;
    step();
    restart = 0;
    check("ign_ready", s_ready, 1);
    check("ign_ramrst", RAM_Reset, 0);
    check("ign_cpu", cpu_reset, 1);
    cur[0] = 32'h00000008;
    load(1, 0, 1);
    release_check(1);
    do_restart();
    cur = img;
    load(3, 0, 0);
    #2;
    reset = 0;
    #1;
    check_reset_vals();
    step();
    reset = 1;
    step();
    check("reload_ready", s_ready, 1);
    for (int i = 0; i < 7; i++) cur[i] = $urandom;
    load(7, 2, 1);
    release_check(7);
    s_valid4 = 1;
    for (int i = 0; i < 3; i++) begin
      s_data4 = $urandom;
      step();
      check("ovf_wr_en", inst_input4, 1);
      check("ovf_wr_addr", inst_addr4, 4 + 4 * i);
      check("ovf_wr_data", instruction4, s_data4);
      check("ovf_flag", overflow4, i == 2);
    end
    check("ovf_ready", s_ready4, 0);
    check("ovf_count", word_count4, 3);
    for (int i = 0; i < 4; i++) begin
      s_data4 = $urandom;
      step();
      check("ovf_no_wr", inst_input4, 0);
      check("ovf_cpu", cpu_reset4, 1);
      check("ovf_sticky", overflow4, 1);
      check("ovf_done", load_done4, 0);
    end
    s_valid4 = 0;
    check("ovf_zero_wr", zero_write4, 0);
    check("ovf_writes", writes4, 3);
    restart4 = 1;
    step();
    restart4 = 0;
    check("ovf_clr", overflow4, 0);
    check("ovf_rs_ramrst", RAM_Reset4, 1);
    step();
    check("ovf_rs_ready", s_ready4, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
